// File: rtl/telemetria_tx.sv
// Telemetry return-path UART transmitter: snapshots plant state on request and
// sends a 7-byte 8N1 frame (header, humidity, time, plant type, checksum).
module telemetria_tx #(
  parameter int          CLK_HZ = 50_000_000,
  parameter int          BAUD   = 9600,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [11:0] humedad,
  input  logic [15:0] hora,
  input  logic [3:0]  tipoPlanta,
  input  logic        regar,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  typedef struct packed {
    logic        regar;
    logic [11:0] humedad;
    logic [15:0] hora;
    logic [3:0]  tipo;
  } snap_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [2:0]    byte_idx, byte_n;
  snap_t         snap, snap_n;
  logic          tx_n, busy_n, done_n;
  logic          bit_end;
  logic [7:0]    cur_byte;

  // Byte 6 is the modular sum of bytes 0..5, always taken from the snapshot.
  function automatic logic [7:0] frame_byte(input snap_t s, input logic [2:0] idx);
    logic [7:0] b1, b2, b3, b4, b5;
    b1 = {s.regar, 3'b000, s.humedad[11:8]};
    b2 = s.humedad[7:0];
    b3 = s.hora[15:8];
    b4 = s.hora[7:0];
    b5 = {4'h0, s.tipo};
    case (idx)
      3'd0:    return HEADER;
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      3'd4:    return b4;
      3'd5:    return b5;
      3'd6:    return HEADER + b1 + b2 + b3 + b4 + b5;
      default: return 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      snap     <= snap_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  assign bit_end = (cnt == CW'(DIV - 1));

  // DONE also accepts a new request so back-to-back frames have a single idle cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    snap_n  = snap;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (send) begin
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
          byte_n  = '0;
          snap_n  = '{regar: regar, humedad: humedad, hora: hora, tipo: tipoPlanta};
        end
      end
      START: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx == 3'd6) begin
            state_n = DONE;
          end else begin
            byte_n  = byte_idx + 1'b1;
            state_n = START;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so tx never glitches.
  always_comb begin
    cur_byte = frame_byte(snap_n, byte_n);
    tx_n     = 1'b1;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      DATA: begin
        tx_n   = cur_byte[bit_n];
        busy_n = 1'b1;
      end
      STOP:    busy_n = 1'b1;
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_telemetria_tx.sv
// Bench for telemetria_tx: mid-bit sampling UART receiver checked against a
// byte-level frame model built from the plant-state values.
module tb_telemetria_tx;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic [11:0] humedad = '0;
  logic [15:0] hora = '0;
  logic [3:0]  tipoPlanta = '0;
  logic        regar = 1'b0;
  logic        tx, busy, done;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          acc = 0;
  int          bad_cnt;
  logic [55:0] got1, got2, exp1, exp2;
  bit          bad1, bad2;
  int          rh, rt, rp, rr;

  telemetria_tx #(.CLK_HZ(16), .BAUD(1), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .send(send), .humedad(humedad), .hora(hora),
    .tipoPlanta(tipoPlanta), .regar(regar), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Frame built from the values with plain arithmetic; byte i sits at [8*i +: 8].
  function automatic logic [55:0] model(input int h, input int t, input int p, input int r);
    int b[7];
    int s;
    logic [55:0] f;
    b[0] = 165;
    b[1] = r * 128 + h / 256;
    b[2] = h % 256;
    b[3] = t / 256;
    b[4] = t % 256;
    b[5] = p;
    s = 0;
    for (int i = 0; i < 6; i++) s += b[i];
    b[6] = s % 256;
    f = '0;
    for (int i = 0; i < 7; i++) f[8*i +: 8] = b[i][7:0];
    return f;
  endfunction

  task automatic rx_byte(output logic [7:0] b, output bit bad);
    int n;
    bad = 1'b0;
    b = '0;
    n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      bad = 1'b1;
      return;
    end
    repeat (DIV / 2) tick();
    if (tx !== 1'b0) bad = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) tick();
      b[i] = tx;
    end
    repeat (DIV) tick();
    if (tx !== 1'b1) bad = 1'b1;
  endtask

  task automatic rx_frame(output logic [55:0] f, output bit bad);
    logic [7:0] b;
    bit         e;
    bad = 1'b0;
    f = '0;
    for (int i = 0; i < 7; i++) begin
      rx_byte(b, e);
      f[8*i +: 8] = b;
      bad = bad | e;
    end
  endtask

  task automatic compare_frame(input string tag, input logic [55:0] got, input bit bad,
                               input logic [55:0] exp);
    check({tag, " framing"}, 32'(bad), 32'd0);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s byte%0d", tag, i), 32'(got[8*i +: 8]), 32'(exp[8*i +: 8]));
  endtask

  task automatic apply_inputs(input int h, input int t, input int p, input int r);
    humedad    = 12'(h);
    hora       = 16'(t);
    tipoPlanta = 4'(p);
    regar      = 1'(r);
  endtask

  task automatic start_frame(input int h, input int t, input int p, input int r);
    apply_inputs(h, t, p, r);
    send = 1'b1;
    tick();
    send = 1'b0;
    acc = cyc;
    check("accept busy", 32'(busy), 32'd1);
    check("accept tx", 32'(tx), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, " done latency"}, 32'(cyc - acc), 32'd1120);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset and idle line
    repeat (3) tick();
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    bad_cnt = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad_cnt++;
    end
    check("idle line", 32'(bad_cnt), 32'd0);

    // Single directed frame
    start_frame('h3FF, 'h1230, 'h2, 1);
    rx_frame(got1, bad1);
    compare_frame("single", got1, bad1, 56'h6B_02_30_12_FF_83_A5);
    wait_done("single");
    tick();
    check("done pulse width", 32'(done), 32'd0);
    repeat (5) tick();

    // Snapshot: humidity changes while byte 1 is on the line
    start_frame('h3FF, 'h1230, 'h2, 1);
    fork
      rx_frame(got1, bad1);
      begin
        repeat (10 * DIV + 3) tick();
        humedad = 12'h000;
      end
    join
    compare_frame("snapshot", got1, bad1, 56'h6B_02_30_12_FF_83_A5);
    wait_done("snapshot");
    repeat (5) tick();

    // A send while busy is dropped
    rh = int'($urandom_range(4095)); rt = int'($urandom_range(65535));
    rp = int'($urandom_range(15));   rr = int'($urandom_range(1));
    start_frame(rh, rt, rp, rr);
    exp1 = model(rh, rt, rp, rr);
    fork
      rx_frame(got1, bad1);
      begin
        repeat (199) tick();
        send = 1'b1;
        tick();
        send = 1'b0;
      end
    join
    compare_frame("busy ignore", got1, bad1, exp1);
    wait_done("busy ignore");
    bad_cnt = 0;
    repeat (300) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_cnt++;
    end
    check("no queued frame", 32'(bad_cnt), 32'd0);

    // Reset during B3 data bit 4 (a zero bit, so the jump to 1 is visible)
    start_frame('h155, 'h0830, 'h7, 0);
    repeat (35 * DIV + DIV / 2) tick();
    check("pre-reset tx", 32'(tx), 32'd0);
    rst = 1'b1;
    tick();
    check("midreset tx", 32'(tx), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    rst = 1'b0;
    bad_cnt = 0;
    repeat (1300) begin
      tick();
      if (tx !== 1'b1 || done !== 1'b0) bad_cnt++;
    end
    check("abandoned frame", 32'(bad_cnt), 32'd0);

    // Random frames, inputs scrambled mid-frame
    for (int k = 0; k < 3; k++) begin
      rh = int'($urandom_range(4095)); rt = int'($urandom_range(65535));
      rp = int'($urandom_range(15));   rr = int'($urandom_range(1));
      start_frame(rh, rt, rp, rr);
      exp1 = model(rh, rt, rp, rr);
      fork
        rx_frame(got1, bad1);
        begin
          repeat (100) tick();
          apply_inputs(int'($urandom_range(4095)), int'($urandom_range(65535)),
                       int'($urandom_range(15)), int'($urandom_range(1)));
        end
      join
      compare_frame($sformatf("random%0d", k), got1, bad1, exp1);
      wait_done($sformatf("random%0d", k));
      repeat (3) tick();
    end

    // Back-to-back with send held high
    rh = int'($urandom_range(4095)); rt = int'($urandom_range(65535));
    rp = int'($urandom_range(15));   rr = int'($urandom_range(1));
    apply_inputs(rh, rt, rp, rr);
    exp1 = model(rh, rt, rp, rr);
    send = 1'b1;
    tick();
    acc = cyc;
    rh = int'($urandom_range(4095)); rt = int'($urandom_range(65535));
    rp = int'($urandom_range(15));   rr = int'($urandom_range(1));
    exp2 = model(rh, rt, rp, rr);
    fork
      rx_frame(got1, bad1);
      begin
        repeat (300) tick();
        apply_inputs(rh, rt, rp, rr);
      end
    join
    compare_frame("b2b first", got1, bad1, exp1);
    wait_done("b2b first");
    tick();
    acc = cyc;
    check("b2b restart tx", 32'(tx), 32'd0);
    check("b2b restart busy", 32'(busy), 32'd1);
    fork
      rx_frame(got2, bad2);
      begin
        repeat (50) tick();
        send = 1'b0;
        apply_inputs(int'($urandom_range(4095)), int'($urandom_range(65535)),
                     int'($urandom_range(15)), int'($urandom_range(1)));
      end
    join
    compare_frame("b2b second", got2, bad2, exp2);
    wait_done("b2b second");
    repeat (5) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
